// File: rtl/noise_fill_ctrl.sv
// Fill sequencer for the noise memory banks: owns the Galois LFSR and sweeps every
// address of the selected banks once per start request, reporting busy/done/count.
module noise_fill_ctrl #(
  parameter int          pBANKS        = 16,
  parameter int          pADDR_BITS    = 3,
  parameter logic [31:0] pLFSR_TAPS    = 32'h80200003,
  parameter logic [31:0] pSEED_DEFAULT = 32'h00000001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           I_seed,
  input  logic                  I_seed_load,
  input  logic                  I_start,
  input  logic [pBANKS-1:0]     I_bank_mask,
  input  logic                  I_hold,
  input  logic                  I_abort,
  output logic                  O_wr_en,
  output logic [pADDR_BITS-1:0] O_wr_addr,
  output logic [pBANKS-1:0]     O_enable,
  output logic [31:0]           O_lfsr_state,
  output logic                  O_busy,
  output logic                  O_done,
  output logic [15:0]           O_fill_count
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [pADDR_BITS-1:0] ADDR_LAST = '1;

  state_t                  state_q, state_d;
  logic [pADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]             lfsr_q, lfsr_d;
  logic [pBANKS-1:0]       mask_q, mask_d;
  logic [15:0]             fill_count_q, fill_count_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return cur[0] ? ((cur >> 1) ^ pLFSR_TAPS) : (cur >> 1);
  endfunction

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lfsr_d       = lfsr_q;
    mask_d       = mask_q;
    fill_count_d = fill_count_q;
    case (state_q)
      IDLE: begin
        // A seed load in the start cycle is applied first, so the fill uses the new seed.
        if (I_seed_load) lfsr_d = (I_seed == '0) ? pSEED_DEFAULT : I_seed;
        if (I_start) begin
          if (I_bank_mask != '0) begin
            mask_d  = I_bank_mask;
            addr_d  = '0;
            state_d = FILL;
          end else begin
            state_d = DONE;
          end
        end
      end
      FILL: begin
        if (I_abort) begin
          state_d = IDLE;
        end else if (!I_hold) begin
          addr_d = addr_q + 1'b1;
          lfsr_d = lfsr_step(lfsr_q);
          if (addr_q == ADDR_LAST) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Count on entry to DONE so the new value is visible alongside the done pulse.
    if (state_d == DONE && fill_count_q != 16'hFFFF) fill_count_d = fill_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lfsr_q       <= pSEED_DEFAULT;
      mask_q       <= '0;
      fill_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lfsr_q       <= lfsr_d;
      mask_q       <= mask_d;
      fill_count_q <= fill_count_d;
    end
  end

  assign O_wr_en      = (state_q == FILL) && !I_hold && !I_abort;
  assign O_wr_addr    = addr_q;
  assign O_enable     = (state_q == FILL) ? mask_q : '0;
  assign O_lfsr_state = lfsr_q;
  assign O_busy       = (state_q != IDLE);
  assign O_done       = (state_q == DONE);
  assign O_fill_count = fill_count_q;

endmodule
